// File: rtl/adc_clkgen_sync.sv
// Synchronous SAR ADC clock generator: sample pulse, then NCYC rounds of
// comparator-reset settle (D1), comparator clock (COMP) and digital clock (D3).
// All phase lengths are counted in clk_in cycles by a single down-counter.
module adc_clkgen_sync #(
  parameter int DLY_W       = 5,
  parameter int PW_W        = 6,
  parameter int NCYC        = 12,
  parameter int TIMEOUT     = 31,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ena_in,
  input  logic             start_conv_in,
  input  logic             ndecision_finish_in,
  input  logic             enable_dlycontrol_in,
  input  logic [DLY_W-1:0] dlycontrol1_in,
  input  logic [DLY_W-1:0] dlycontrol3_in,
  input  logic [PW_W-1:0]  dlycontrol4_in,
  output logic             clk_comp_out,
  output logic             clk_dig_out,
  output logic             sample_out,
  output logic             nsample_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             timeout_out,
  output logic             overrun_out,
  output logic [7:0]       cycle_cnt_out
);

  // The shared phase counter must hold the widest delay and the timeout.
  localparam int CW0   = (DLY_W > PW_W) ? DLY_W : PW_W;
  localparam int CNT_W = (CW0 > 8) ? CW0 : 8;

  typedef enum logic [2:0] {IDLE, SAMPLE, D1, COMP, D3, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [7:0]             cyc_next;
  logic                   to_next, ov_next;
  logic [SYNC_STAGES-1:0] start_sync_reg, ndec_sync_reg;
  logic                   start_d_reg, start_edge_reg;
  logic                   decision;
  logic [CNT_W-1:0]       eff1, eff3, eff4;

  // Effective delay: all ones when controls are disabled, and zero means one.
  function automatic logic [CNT_W-1:0] eff_dly(input logic [DLY_W-1:0] v, input logic use_ctl);
    logic [DLY_W-1:0] x;
    x = use_ctl ? v : '1;
    if (x == '0) x = DLY_W'(1);
    return CNT_W'(x);
  endfunction

  function automatic logic [CNT_W-1:0] eff_pw(input logic [PW_W-1:0] v, input logic use_ctl);
    logic [PW_W-1:0] x;
    x = use_ctl ? v : '1;
    if (x == '0) x = PW_W'(1);
    return CNT_W'(x);
  endfunction

  assign eff1     = eff_dly(dlycontrol1_in, enable_dlycontrol_in);
  assign eff3     = eff_dly(dlycontrol3_in, enable_dlycontrol_in);
  assign eff4     = eff_pw(dlycontrol4_in, enable_dlycontrol_in);
  assign decision = ~ndec_sync_reg[SYNC_STAGES-1];

  // Synchronise the asynchronous request/decision inputs and register the start edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      start_sync_reg <= '0;
      ndec_sync_reg  <= '1;
      start_d_reg    <= 1'b0;
      start_edge_reg <= 1'b0;
    end else begin
      start_sync_reg <= {start_sync_reg[SYNC_STAGES-2:0], start_conv_in};
      ndec_sync_reg  <= {ndec_sync_reg[SYNC_STAGES-2:0], ndecision_finish_in};
      start_d_reg    <= start_sync_reg[SYNC_STAGES-1];
      start_edge_reg <= start_sync_reg[SYNC_STAGES-1] & ~start_d_reg;
    end
  end

  // Next-state, phase counter and status-flag computation.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cyc_next   = cycle_cnt_out;
    to_next    = timeout_out;
    ov_next    = overrun_out;
    // A request while a conversion is running is dropped but remembered.
    if (ena_in && start_edge_reg && state_reg != IDLE && state_reg != DONE)
      ov_next = 1'b1;
    if (!ena_in) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_edge_reg) begin
            state_next = SAMPLE;
            cnt_next   = eff4;
            to_next    = 1'b0;
            ov_next    = 1'b0;
            cyc_next   = 8'd0;
          end
        end
        SAMPLE: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_next = D1;
            cnt_next   = eff1;
          end else cnt_next = cnt_reg - CNT_W'(1);
        end
        D1: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_next = COMP;
            cnt_next   = CNT_W'(TIMEOUT);
          end else cnt_next = cnt_reg - CNT_W'(1);
        end
        COMP: begin
          if (decision) begin
            state_next = D3;
            cnt_next   = eff3;
          end else if (cnt_reg == CNT_W'(1)) begin
            state_next = D3;
            cnt_next   = eff3;
            to_next    = 1'b1;
          end else cnt_next = cnt_reg - CNT_W'(1);
        end
        D3: begin
          if (cnt_reg == CNT_W'(1)) begin
            cyc_next   = cycle_cnt_out + 8'd1;
            state_next = (cycle_cnt_out + 8'd1 == 8'(NCYC)) ? DONE : D1;
            cnt_next   = eff1;
          end else cnt_next = cnt_reg - CNT_W'(1);
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register with outputs decoded from the next state so they switch with it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cycle_cnt_out <= 8'd0;
      timeout_out   <= 1'b0;
      overrun_out   <= 1'b0;
      sample_out    <= 1'b0;
      nsample_out   <= 1'b1;
      clk_comp_out  <= 1'b0;
      clk_dig_out   <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cycle_cnt_out <= cyc_next;
      timeout_out   <= to_next;
      overrun_out   <= ov_next;
      sample_out    <= (state_next == SAMPLE);
      nsample_out   <= (state_next != SAMPLE);
      clk_comp_out  <= (state_next == COMP);
      clk_dig_out   <= (state_next == D3);
      busy_out      <= (state_next != IDLE) && (state_next != DONE);
      done_out      <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_adc_clkgen_sync.sv
// Bench for adc_clkgen_sync: a phase-schedule model turns a pre-generated
// per-cycle input trace into the expected per-cycle output trace.
module tb_adc_clkgen_sync;
  localparam int S    = 2;
  localparam int NC   = 3;
  localparam int TO   = 31;
  localparam int MAXL = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, start, ndec, edc;
  logic [4:0] d1, d3;
  logic [5:0] d4;
  logic       clk_comp, clk_dig, sample, nsample, busy, done, tmo, ovr;
  logic [7:0] cyc;

  adc_clkgen_sync #(.DLY_W(5), .PW_W(6), .NCYC(NC), .TIMEOUT(TO), .SYNC_STAGES(S)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .ena_in(ena), .start_conv_in(start),
    .ndecision_finish_in(ndec), .enable_dlycontrol_in(edc),
    .dlycontrol1_in(d1), .dlycontrol3_in(d3), .dlycontrol4_in(d4),
    .clk_comp_out(clk_comp), .clk_dig_out(clk_dig), .sample_out(sample),
    .nsample_out(nsample), .busy_out(busy), .done_out(done),
    .timeout_out(tmo), .overrun_out(ovr), .cycle_cnt_out(cyc));

  int compared = 0, mismatched = 0;
  int L;
  bit st_a[MAXL], nd_a[MAXL], en_a[MAXL], edc_a[MAXL];
  int c1_a[MAXL], c3_a[MAXL], c4_a[MAXL];
  // {sample, nsample, comp, dig, busy, done, timeout, overrun, cnt[7:0]}
  logic [15:0] exp_a[MAXL], obs_a[MAXL];

  typedef enum {P_IDLE, P_SAMPLE, P_D1, P_COMP, P_D3, P_DONE} ph_t;
  bit m_to, m_ov;
  int m_cnt;

  function automatic bit s_at(int i);
    return (i < 0 || i >= L) ? 1'b0 : st_a[i];
  endfunction
  function automatic bit n_at(int i);
    return (i < 0 || i >= L) ? 1'b1 : nd_a[i];
  endfunction
  // Start request as seen by the transition at edge k (sync chain plus edge register).
  function automatic bit sedge(int k);
    return s_at(k - 1 - S) && !s_at(k - 2 - S);
  endfunction
  function automatic bit dec_at(int k);
    return !n_at(k - S);
  endfunction
  function automatic int eff(int v, bit use_ctl, int ones);
    if (!use_ctl) return ones;
    return (v == 0) ? 1 : v;
  endfunction
  function automatic void emit(int k, ph_t p);
    exp_a[k] = {(p == P_SAMPLE), (p != P_SAMPLE), (p == P_COMP), (p == P_D3),
                (p != P_IDLE && p != P_DONE), (p == P_DONE), m_to, m_ov, 8'(m_cnt)};
  endfunction

  // Emit one phase starting at j; stops on ena low (that cycle is IDLE) or trace end.
  task automatic run_phase(inout int j, input ph_t p, input int fixed_len,
                           input bit set_to, input bit inc, output bit ab);
    int len;
    len = 1;
    ab = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (j >= L) begin ab = 1'b1; return; end
      if (!en_a[j]) begin emit(j, P_IDLE); j++; ab = 1'b1; return; end
      if (i == 0) begin
        case (p)
          P_SAMPLE: len = eff(c4_a[j], edc_a[j], 63);
          P_D1:     len = eff(c1_a[j], edc_a[j], 31);
          P_D3:     len = eff(c3_a[j], edc_a[j], 31);
          default:  len = fixed_len;
        endcase
        if (set_to) m_to = 1'b1;
        if (inc) m_cnt++;
      end
      if (sedge(j) && !(p == P_SAMPLE && i == 0)) m_ov = 1'b1;
      emit(j, p);
      j++;
      if (i + 1 >= len) break;
    end
  endtask

  task automatic gen_conv(inout int j);
    bit ab, tm;
    int len;
    m_to = 1'b0; m_ov = 1'b0; m_cnt = 0;
    run_phase(j, P_SAMPLE, 0, 1'b0, 1'b0, ab); if (ab) return;
    for (int b = 0; b < NC; b++) begin
      run_phase(j, P_D1, 0, 1'b0, (b > 0), ab); if (ab) return;
      len = TO; tm = 1'b1;
      for (int i = 0; i < TO; i++) if (dec_at(j + i + 1)) begin len = i + 1; tm = 1'b0; break; end
      run_phase(j, P_COMP, len, 1'b0, 1'b0, ab); if (ab) return;
      run_phase(j, P_D3, 0, tm, 1'b0, ab); if (ab) return;
    end
    run_phase(j, P_DONE, 1, 1'b0, 1'b1, ab); if (ab) return;
    if (j < L) begin emit(j, P_IDLE); j++; end
  endtask

  task automatic gen_model();
    int k;
    k = 0; m_to = 1'b0; m_ov = 1'b0; m_cnt = 0;
    while (k < L) begin
      if (en_a[k] && sedge(k)) gen_conv(k);
      else begin emit(k, P_IDLE); k++; end
    end
  endtask

  task automatic set_defaults(input int len);
    L = len;
    for (int k = 0; k < MAXL; k++) begin
      st_a[k] = 1'b0; nd_a[k] = 1'b0; en_a[k] = 1'b1; edc_a[k] = 1'b1;
      c1_a[k] = 2; c3_a[k] = 3; c4_a[k] = 4;
    end
  endtask

  task automatic build_random();
    bit sl, nl, el;
    int a, b, c;
    sl = 1'b0; nl = 1'b1; el = 1'b1; a = 2; b = 3; c = 4;
    L = 900;
    for (int k = 0; k < MAXL; k++) begin
      if ($urandom_range(39) == 0) sl = !sl;
      if ($urandom_range(2) == 0) nl = !nl;
      if ($urandom_range(99) == 0) el = !el;
      if ($urandom_range(49) == 0) a = int'($urandom_range(31));
      if ($urandom_range(49) == 0) b = int'($urandom_range(31));
      if ($urandom_range(49) == 0) c = int'($urandom_range(63));
      st_a[k] = sl; nd_a[k] = nl; edc_a[k] = el;
      en_a[k] = ($urandom_range(299) != 0);
      c1_a[k] = a; c3_a[k] = b; c4_a[k] = c;
    end
  endtask

  task automatic drive(input int k);
    ena = en_a[k]; start = st_a[k]; ndec = nd_a[k]; edc = edc_a[k];
    d1 = 5'(c1_a[k]); d3 = 5'(c3_a[k]); d4 = 6'(c4_a[k]);
  endtask

  function automatic logic [15:0] outs();
    return {sample, nsample, clk_comp, clk_dig, busy, done, tmo, ovr, cyc};
  endfunction

  task automatic lit(input string nm, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  function automatic int first_hi(bit use_exp, int b);
    for (int k = 0; k < L; k++) if (use_exp ? exp_a[k][b] : obs_a[k][b]) return k;
    return -1;
  endfunction
  function automatic int count_hi(bit use_exp, int b);
    int n;
    n = 0;
    for (int k = 0; k < L; k++) if (use_exp ? exp_a[k][b] : obs_a[k][b]) n++;
    return n;
  endfunction

  // Reset, then replay the trace cycle by cycle, comparing every cycle to the model.
  task automatic run_scn(input int id, input string nm, input int stop_at);
    int bad;
    bad = 0;
    gen_model();
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; ndec = 1'b1; edc = 1'b1;
    d1 = '0; d3 = '0; d4 = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (outs() !== 16'h4000) begin
      mismatched++; bad++;
      $display("FAIL reset_state scn %0d: got %h, expected 4000", id, outs());
    end
    rst_n = 1'b1;
    for (int k = 0; k < stop_at; k++) begin
      drive(k);
      @(posedge clk);
      @(negedge clk);
      obs_a[k] = outs();
      compared++;
      if (obs_a[k] !== exp_a[k]) begin
        mismatched++; bad++;
        if (bad <= 10)
          $display("FAIL trace scn %0d cyc %0d: got %h, expected %h", id, k, obs_a[k], exp_a[k]);
      end
    end
    $display("scenario %0d %s: %0d cycles checked, %0d bad", id, nm, stop_at, bad);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; ndec = 1'b1; edc = 1'b1;
    d1 = '0; d3 = '0; d4 = '0;

    // 1: basic conversion, D1=2 D3=3 D4=4, decision always present.
    set_defaults(60);
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    run_scn(1, "basic", L);
    lit("basic_model_done_at", first_hi(1, 10), 30);
    lit("basic_sample_first", first_hi(0, 15), 8);
    lit("basic_sample_len", count_hi(0, 15), 4);
    lit("basic_comp_first", first_hi(0, 13), 14);
    lit("basic_comp_total", count_hi(0, 13), 3);
    lit("basic_dig_total", count_hi(0, 12), 9);
    lit("basic_done_at", first_hi(0, 10), 30);
    lit("basic_done_count", count_hi(0, 10), 1);
    lit("basic_cnt_final", int'(obs_a[L-1][7:0]), 3);
    lit("basic_busy_after", int'(obs_a[30][11]), 0);

    // 2: no decision ever; every COMP phase times out.
    set_defaults(140);
    for (int k = 0; k < L; k++) nd_a[k] = 1'b1;
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    run_scn(2, "timeout", L);
    lit("tmo_model_done_at", first_hi(1, 10), 120);
    lit("tmo_first_set", first_hi(0, 9), 45);
    lit("tmo_comp_total", count_hi(0, 13), 93);
    lit("tmo_done_at", first_hi(0, 10), 120);

    // 3: controls disabled -> all-ones delays.
    set_defaults(280);
    for (int k = 0; k < L; k++) edc_a[k] = 1'b0;
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    run_scn(3, "max_delays", L);
    lit("max_sample_len", count_hi(0, 15), 63);
    lit("max_done_at", first_hi(0, 10), 260);

    // 4: zero controls -> one-cycle phases.
    set_defaults(30);
    for (int k = 0; k < L; k++) begin c1_a[k] = 0; c3_a[k] = 0; c4_a[k] = 0; end
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    run_scn(4, "zero_ctl", L);
    lit("zero_sample_len", count_hi(0, 15), 1);
    lit("zero_done_at", first_hi(0, 10), 18);

    // 5: second request lands in D3 of the first round, third request after DONE.
    set_defaults(80);
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    st_a[13] = 1'b1; st_a[14] = 1'b1; st_a[40] = 1'b1; st_a[41] = 1'b1;
    run_scn(5, "overrun", L);
    lit("ovr_first_set", first_hi(0, 8), 16);
    lit("ovr_done_at", first_hi(0, 10), 30);
    lit("ovr_cnt_at_done", int'(obs_a[30][7:0]), 3);
    lit("ovr_cleared_restart", int'(obs_a[43][8]), 0);
    lit("ovr_restart_sample", int'(obs_a[43][15]), 1);

    // 6: ena dropped for one cycle during COMP.
    set_defaults(80);
    for (int k = 0; k < L; k++) nd_a[k] = 1'b1;
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    en_a[20] = 1'b0;
    run_scn(6, "ena_abort", L);
    lit("abort_comp_before", int'(obs_a[19][13]), 1);
    lit("abort_comp_after", int'(obs_a[20][13]), 0);
    lit("abort_busy_after", int'(obs_a[20][11]), 0);
    lit("abort_no_done", count_hi(0, 10), 0);

    // 7: request held high -> exactly one conversion.
    set_defaults(100);
    for (int k = 5; k < L; k++) st_a[k] = 1'b1;
    run_scn(7, "held_start", L);
    lit("held_done_count", count_hi(0, 10), 1);

    // 8..12: randomized traces.
    for (int r = 0; r < 5; r++) begin
      build_random();
      run_scn(8 + r, "random", L);
    end

    // 13: asynchronous reset in the middle of SAMPLE.
    set_defaults(20);
    for (int k = 5; k < 8; k++) st_a[k] = 1'b1;
    run_scn(13, "reset_mid_sample", 10);
    lit("rst_in_sample", int'(sample), 1);
    #2 rst_n = 1'b0;
    #1;
    lit("rst_sample_low", int'(sample), 0);
    lit("rst_nsample_high", int'(nsample), 1);
    lit("rst_busy_low", int'(busy), 0);
    #2 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
